surfctl_cout_checker: RTL
=========================

SURFCTL_COUT_CHECKER -- requirements
Module: surfctl_cout_checker

Interface
REQ-001 SHALL have parameter TRAIN_PATTERN, default 32'hA55A6996, the expected 32-bit COUT training word.
REQ-002 SHALL have parameter LOCK_COUNT, default 16, the consecutive good words needed to lock (legal 1..255).
REQ-003 SHALL have port sysclk_i  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port sysclk_rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port iserdes_data_i  input  4  deserialized COUT nibble, one per sysclk_i; earliest bit in [3].
REQ-006 SHALL have port iserdes_rst_i  input  1  synchronous ISERDES reset (already sysclk-synchronized); clears framing.
REQ-007 SHALL have port check_enable_i  input  1  level; enables pattern checking.
REQ-008 SHALL have port nibble_slip_i  input  1  one-cycle pulse; shifts the word boundary by one nibble.
REQ-009 SHALL have port cout_capture_i  input  1  one-cycle pulse; latches the most recent complete word.
REQ-010 SHALL have port cout_data_o  output  32  captured word.
REQ-011 SHALL have port cout_biterr_o  output  1  one-cycle pulse per mismatched word; feeds the bit-error timed counter.
REQ-012 SHALL have port word_valid_o  output  1  one-cycle pulse per completed word.
REQ-013 SHALL have port locked_o  output  1  level; high in LOCKED state.

Function
REQ-014 SHALL shift each nibble into a 32-bit register as {sr[27:0], iserdes_data_i}, so the first nibble of a word lands in [31:28].
REQ-015 SHALL keep a 3-bit nibble counter that increments each cycle and wraps 7->0; the cycle with counter==7 completes a word.
REQ-016 SHALL register the completed word and assert word_valid_o exactly one cycle after the completing nibble (latency 1).
REQ-017 SHALL, on nibble_slip_i, hold the counter for that cycle (boundary moves one nibble later); the shift register keeps shifting.
REQ-018 SHALL, if nibble_slip_i coincides with counter==7, suppress that word completion; the word completes one cycle later.
REQ-019 SHALL compare each completed word to TRAIN_PATTERN when check_enable_i is high; on mismatch, cout_biterr_o pulses in the same cycle as word_valid_o.
REQ-020 SHALL hold cout_biterr_o low while check_enable_i is low.
REQ-021 SHALL implement FSM states UNLOCKED, ACQUIRE and LOCKED with an 8-bit good-word counter.
REQ-022 SHALL make these FSM transitions: UNLOCKED goes to ACQUIRE on a good word; ACQUIRE goes to LOCKED when the good-word counter reaches LOCK_COUNT; any mismatch in any state goes to UNLOCKED and clears the counter.
REQ-023 SHALL, with LOCK_COUNT==1, go from UNLOCKED directly to LOCKED on the first good word.
REQ-024 SHALL force the FSM to UNLOCKED and clear the counter while check_enable_i is low.
REQ-025 SHALL, on cout_capture_i, load cout_data_o on the next edge with the most recent registered word.
REQ-026 SHALL, if cout_capture_i coincides with a word completion, capture the newly completed word.
REQ-027 SHALL, on iserdes_rst_i, clear the counter, shift register and FSM synchronously; word_valid_o and cout_biterr_o stay low that cycle; cout_data_o is retained.

Reset
REQ-028 SHALL, while sysclk_rst_n_i is low, clear asynchronously: cout_data_o=0, cout_biterr_o=0, word_valid_o=0, locked_o=0, FSM=UNLOCKED, counters=0, shift register=0.
REQ-029 SHALL start the first word after reset release with the first nibble sampled after deassertion (8 cycles to first word_valid_o).
REQ-030 SHALL leave the outputs at their reset values when reset is asserted mid-word, and SHALL not produce any partial-word pulse after release.

Configuration
REQ-031 SHALL, with SURFCTL_COUT_AUTOSLIP_EN defined, issue an internal nibble slip on every mismatch seen in UNLOCKED or ACQUIRE, OR-ed with nibble_slip_i, and skip checking of the one word that follows.
REQ-032 SHALL, with SURFCTL_COUT_AUTOSLIP_EN undefined, slip only via nibble_slip_i, and SHALL remove all autoslip logic.

Verification
REQ-033 SHALL cover: repeated nibbles A,5,5,A,6,9,9,6 with enable high -> word_valid_o every 8 cycles, no biterr, locked_o high after the 16th good word.
REQ-034 SHALL cover: the stream offset by 3 nibbles with no autoslip -> biterr on every word; 3 nibble_slip_i pulses -> biterr stops, lock after 16 more words.
REQ-035 SHALL cover: a locked stream with one word corrupted to 32'hA55A6997 -> a single biterr pulse, locked_o drops, relock after 16 good words.
REQ-036 SHALL cover: cout_capture_i coincident with a completed 32'h12345678 -> cout_data_o==32'h12345678 one cycle later.
REQ-037 SHALL cover: sysclk_rst_n_i low for 2 cycles mid-word -> all outputs 0 immediately; first word_valid_o 8 cycles after release.
REQ-038 SHALL cover: with SURFCTL_COUT_AUTOSLIP_EN defined and a 5-nibble offset -> automatic slips until aligned, locked_o high without nibble_slip_i.

Source files
------------

// File: rtl/surfctl_cout_checker.sv
// COUT training-word checker: nibble framing, pattern compare, lock FSM and capture.
// Optional build macro SURFCTL_COUT_AUTOSLIP_EN adds automatic nibble slipping on mismatch.
module surfctl_cout_checker #(
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
    parameter int unsigned LOCK_COUNT    = 16
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_n_i,
    input  logic [3:0]  iserdes_data_i,
    input  logic        iserdes_rst_i,
    input  logic        check_enable_i,
    input  logic        nibble_slip_i,
    input  logic        cout_capture_i,
    output logic [31:0] cout_data_o,
    output logic        cout_biterr_o,
    output logic        word_valid_o,
    output logic        locked_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SR_W   = WORD_W - NIB_W;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned GOOD_W = 8;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(7);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_COUNT);

    // Only the seven oldest nibbles are stored; the eighth arrives on the completing cycle.
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] cout_data_q, cout_data_d;
    logic              word_valid_q, word_valid_d;
    logic              biterr_q, biterr_d;
    logic              locked_q, locked_d;
    logic [1:0]        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic [WORD_W-1:0] word_c;
    logic              slip_c;
    logic              complete_c;
    logic              check_c;
    logic              match_c;

    assign word_c     = {sr_q, iserdes_data_i};
    assign match_c    = (word_c == TRAIN_PATTERN);
    assign complete_c = (cnt_q == CNT_LAST) && !slip_c;

`ifdef SURFCTL_COUT_AUTOSLIP_EN
    logic auto_slip_q, auto_slip_d;
    logic skip_q, skip_d;

    assign slip_c  = nibble_slip_i | auto_slip_q;
    // The first word after an automatic slip straddles the old boundary, so it is not judged.
    assign check_c = complete_c && check_enable_i && !skip_q;
`else
    assign slip_c  = nibble_slip_i;
    assign check_c = complete_c && check_enable_i;
`endif

    // Next-state logic for framing, lock FSM and capture.
    always_comb begin
        sr_d         = word_c[SR_W-1:0];
        cnt_d        = slip_c ? cnt_q : cnt_q + CNT_W'(1);
        word_d       = complete_c ? word_c : word_q;
        word_valid_d = complete_c;
        biterr_d     = check_c && !match_c;
        state_d      = state_q;
        good_d       = good_q;
`ifdef SURFCTL_COUT_AUTOSLIP_EN
        auto_slip_d  = check_c && !match_c && (state_q != ST_LOCKED);
        skip_d       = auto_slip_d || (skip_q && !complete_c);
`endif

        if (!check_enable_i) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
        end else if (check_c) begin
            if (!match_c) begin
                state_d = ST_UNLOCKED;
                good_d  = '0;
            end else begin
                case (state_q)
                    ST_UNLOCKED: begin
                        good_d  = GOOD_W'(1);
                        state_d = (LOCK_TGT == GOOD_W'(1)) ? ST_LOCKED : ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == LOCK_TGT) begin
                            state_d = ST_LOCKED;
                        end
                    end
                    default: begin
                        state_d = ST_LOCKED;
                    end
                endcase
            end
        end

        if (iserdes_rst_i) begin
            sr_d         = '0;
            cnt_d        = '0;
            word_d       = word_q;
            word_valid_d = 1'b0;
            biterr_d     = 1'b0;
            state_d      = ST_UNLOCKED;
            good_d       = '0;
`ifdef SURFCTL_COUT_AUTOSLIP_EN
            auto_slip_d  = 1'b0;
            skip_d       = 1'b0;
`endif
        end

        cout_data_d = cout_capture_i ? word_d : cout_data_q;
        locked_d    = (state_d == ST_LOCKED);
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
        if (!sysclk_rst_n_i) begin
            sr_q         <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            cout_data_q  <= '0;
            word_valid_q <= 1'b0;
            biterr_q     <= 1'b0;
            locked_q     <= 1'b0;
            state_q      <= ST_UNLOCKED;
            good_q       <= '0;
`ifdef SURFCTL_COUT_AUTOSLIP_EN
            auto_slip_q  <= 1'b0;
            skip_q       <= 1'b0;
`endif
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            cout_data_q  <= cout_data_d;
            word_valid_q <= word_valid_d;
            biterr_q     <= biterr_d;
            locked_q     <= locked_d;
            state_q      <= state_d;
            good_q       <= good_d;
`ifdef SURFCTL_COUT_AUTOSLIP_EN
            auto_slip_q  <= auto_slip_d;
            skip_q       <= skip_d;
`endif
        end
    end

    assign cout_data_o   = cout_data_q;
    assign cout_biterr_o = biterr_q;
    assign word_valid_o  = word_valid_q;
    assign locked_o      = locked_q;

endmodule
